// File: rtl/scfifo_legacy_pkg.sv
// scfifo_legacy_pkg: shared types and helpers for the legacy single-clock FIFO controller
//   DEF_LOG_DEPTH/DEF_NUM_WORDS : default geometry
//   IS_POW2                     : default depth fills the whole address space
//   ptr_t                       : default-width address/occupancy type
//   next_ptr()                  : pointer increment that wraps at an arbitrary depth
package scfifo_legacy_pkg;
   localparam int DEF_LOG_DEPTH = 5;
   localparam int DEF_NUM_WORDS = 2**DEF_LOG_DEPTH;
   localparam bit IS_POW2 = (DEF_NUM_WORDS == 2**DEF_LOG_DEPTH);
   typedef logic [DEF_LOG_DEPTH-1:0] ptr_t;
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned num_words);
      return (ptr == num_words - 1) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/scfifo_legacy_ctrl_rdpipe.sv
// scfifo_legacy_ctrl_rdpipe: read-data validity delay line through RAM and optional output register
//   clock, aclr (async), sclr (sync) : timing and clears
//   rd_issue                         : qualified read accepted this cycle
//   rd_valid                         : q holds data for an earlier read
//   oreg_en                          : output-register enable (first-stage valid)
module scfifo_legacy_ctrl_rdpipe #(
   parameter int OREG = 1
)(
   input  logic clock,
   input  logic aclr,
   input  logic sclr,
   input  logic rd_issue,
   output logic rd_valid,
   output logic oreg_en
);
   logic [1:0] stage;
   always_ff @(posedge clock or posedge aclr)
      if (aclr) stage <= '0;
      else if (sclr) stage <= '0;
      else stage <= {stage[0], rd_issue};
   assign rd_valid = (OREG != 0) ? stage[1] : stage[0];
   assign oreg_en = (OREG != 0) & stage[0];
endmodule

// File: rtl/scfifo_legacy_ctrl.sv
// scfifo_legacy_ctrl: pointer, occupancy and read-validity controller for the legacy single-clock FIFO
//   clock, aclr (async), sclr (sync)   : timing and clears
//   wrreq, rdreq                       : raw requests
//   full, empty                        : flags fed back from scfifo_legacy_flags
//   wrreq_safe, rdreq_safe, ram_wren   : qualified requests (combinational)
//   ram_wraddr, ram_rdaddr, capacity   : registered pointers and modular occupancy
//   oreg_en, rd_valid                  : read-data pipeline status
module scfifo_legacy_ctrl
   import scfifo_legacy_pkg::*;
#(
   parameter int LOG_DEPTH               = 5,
   parameter int NUM_WORDS               = 2**LOG_DEPTH,
   parameter int OVERFLOW_CHECKING       = 0,
   parameter int UNDERFLOW_CHECKING      = 0,
   parameter int ADD_RAM_OUTPUT_REGISTER = 1,
   parameter int ALLOW_RWCYCLE_WHEN_FULL = 0
)(
   input  logic                 clock,
   input  logic                 aclr,
   input  logic                 sclr,
   input  logic                 wrreq,
   input  logic                 rdreq,
   input  logic                 full,
   input  logic                 empty,
   output logic                 wrreq_safe,
   output logic                 rdreq_safe,
   output logic                 ram_wren,
   output logic [LOG_DEPTH-1:0] ram_wraddr,
   output logic [LOG_DEPTH-1:0] ram_rdaddr,
   output logic                 oreg_en,
   output logic [LOG_DEPTH-1:0] capacity,
   output logic                 rd_valid
);
   assign rdreq_safe = rdreq & (~empty | (UNDERFLOW_CHECKING == 0));
   // a concurrent read frees a slot, so a write may pass a full FIFO when allowed
   assign wrreq_safe = (OVERFLOW_CHECKING == 0) ? wrreq
                     : wrreq & (~full | ((ALLOW_RWCYCLE_WHEN_FULL != 0) & rdreq_safe));
   assign ram_wren = wrreq_safe;
   always_ff @(posedge clock or posedge aclr)
      if (aclr) begin
         ram_wraddr <= '0;
         ram_rdaddr <= '0;
         capacity   <= '0;
      end else if (sclr) begin
         ram_wraddr <= '0;
         ram_rdaddr <= '0;
         capacity   <= '0;
      end else begin
         if (wrreq_safe) ram_wraddr <= LOG_DEPTH'(next_ptr(32'(ram_wraddr), NUM_WORDS));
         if (rdreq_safe) ram_rdaddr <= LOG_DEPTH'(next_ptr(32'(ram_rdaddr), NUM_WORDS));
         // modular: a full power-of-two FIFO reads 0, resolved downstream with full
         capacity <= capacity + LOG_DEPTH'(wrreq_safe) - LOG_DEPTH'(rdreq_safe);
      end
   scfifo_legacy_ctrl_rdpipe #(.OREG(ADD_RAM_OUTPUT_REGISTER)) u_rdpipe (
      .clock   (clock),
      .aclr    (aclr),
      .sclr    (sclr),
      .rd_issue(rdreq_safe),
      .rd_valid(rd_valid),
      .oreg_en (oreg_en)
   );
endmodule

// File: tb/tb_scfifo_legacy_ctrl.sv
// tb_scfifo_legacy_ctrl: three configurations driven in parallel, checked against an occupancy/pointer model
module tb_scfifo_legacy_ctrl;
   localparam int NW_C    [3] = '{32, 24, 32};
   localparam int OVF_C   [3] = '{1, 1, 0};
   localparam int UNF_C   [3] = '{1, 1, 0};
   localparam int OREG_C  [3] = '{1, 0, 0};
   localparam int ALLOW_C [3] = '{0, 1, 0};
   logic clock = 0, aclr = 1, sclr = 0, wrreq = 0, rdreq = 0, full = 0, empty = 1;
   logic [2:0] ws_o, rs_o, wren_o, oe_o, rv_o;
   logic [2:0][4:0] wa_o, ra_o, cap_o;
   int checks = 0, errors = 0, cyc = 1;
   bit run = 0;
   int m_wa [3], m_ra [3], m_cap [3];
   bit rd_at [3][4096];
   always #5 clock = ~clock;
   scfifo_legacy_ctrl #(.LOG_DEPTH(5), .NUM_WORDS(32), .OVERFLOW_CHECKING(1), .UNDERFLOW_CHECKING(1),
      .ADD_RAM_OUTPUT_REGISTER(1), .ALLOW_RWCYCLE_WHEN_FULL(0)) u0 (
      .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .rdreq(rdreq), .full(full), .empty(empty),
      .wrreq_safe(ws_o[0]), .rdreq_safe(rs_o[0]), .ram_wren(wren_o[0]), .ram_wraddr(wa_o[0]),
      .ram_rdaddr(ra_o[0]), .oreg_en(oe_o[0]), .capacity(cap_o[0]), .rd_valid(rv_o[0]));
   scfifo_legacy_ctrl #(.LOG_DEPTH(5), .NUM_WORDS(24), .OVERFLOW_CHECKING(1), .UNDERFLOW_CHECKING(1),
      .ADD_RAM_OUTPUT_REGISTER(0), .ALLOW_RWCYCLE_WHEN_FULL(1)) u1 (
      .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .rdreq(rdreq), .full(full), .empty(empty),
      .wrreq_safe(ws_o[1]), .rdreq_safe(rs_o[1]), .ram_wren(wren_o[1]), .ram_wraddr(wa_o[1]),
      .ram_rdaddr(ra_o[1]), .oreg_en(oe_o[1]), .capacity(cap_o[1]), .rd_valid(rv_o[1]));
   scfifo_legacy_ctrl #(.LOG_DEPTH(5), .NUM_WORDS(32), .OVERFLOW_CHECKING(0), .UNDERFLOW_CHECKING(0),
      .ADD_RAM_OUTPUT_REGISTER(0), .ALLOW_RWCYCLE_WHEN_FULL(0)) u2 (
      .clock(clock), .aclr(aclr), .sclr(sclr), .wrreq(wrreq), .rdreq(rdreq), .full(full), .empty(empty),
      .wrreq_safe(ws_o[2]), .rdreq_safe(rs_o[2]), .ram_wren(wren_o[2]), .ram_wraddr(wa_o[2]),
      .ram_rdaddr(ra_o[2]), .oreg_en(oe_o[2]), .capacity(cap_o[2]), .rd_valid(rv_o[2]));
   function automatic bit exp_rs(input int i);
      return rdreq && (!empty || UNF_C[i] == 0);
   endfunction
   function automatic bit exp_ws(input int i);
      if (OVF_C[i] == 0) return wrreq;
      return wrreq && (!full || (ALLOW_C[i] != 0 && exp_rs(i)));
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   always @(posedge clock) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (aclr || sclr) begin
            m_wa[i] = 0;
            m_ra[i] = 0;
            m_cap[i] = 0;
            rd_at[i][cyc] = 0;
            rd_at[i][cyc-1] = 0;
         end else begin
            bit w, r;
            w = exp_ws(i);
            r = exp_rs(i);
            if (w) m_wa[i] = (m_wa[i] + 1) % NW_C[i];
            if (r) m_ra[i] = (m_ra[i] + 1) % NW_C[i];
            m_cap[i] = (m_cap[i] + int'(w) - int'(r) + 32) % 32;
            rd_at[i][cyc] = r;
         end
      end
   end
   always @(negedge clock)
      if (run && !aclr)
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d wrreq_safe", i), 32'(ws_o[i]), 32'(exp_ws(i)));
            chk($sformatf("u%0d rdreq_safe", i), 32'(rs_o[i]), 32'(exp_rs(i)));
            chk($sformatf("u%0d ram_wren", i), 32'(wren_o[i]), 32'(exp_ws(i)));
            chk($sformatf("u%0d ram_wraddr", i), 32'(wa_o[i]), m_wa[i]);
            chk($sformatf("u%0d ram_rdaddr", i), 32'(ra_o[i]), m_ra[i]);
            chk($sformatf("u%0d capacity", i), 32'(cap_o[i]), m_cap[i]);
            chk($sformatf("u%0d rd_valid", i), 32'(rv_o[i]),
                32'(OREG_C[i] != 0 ? rd_at[i][cyc-1] : rd_at[i][cyc]));
            chk($sformatf("u%0d oreg_en", i), 32'(oe_o[i]), 32'(OREG_C[i] != 0 && rd_at[i][cyc]));
         end
   task automatic drive(input logic w, r, f, e, s);
      @(posedge clock);
      #2;
      wrreq = w;
      rdreq = r;
      full = f;
      empty = e;
      sclr = s;
   endtask
   task automatic settle;
      @(negedge clock);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) @(posedge clock);
      #2;
      aclr = 0;
      run = 1;
      settle;
      chk("reset capacity", 32'(cap_o[0]), 0);
      chk("reset wraddr", 32'(wa_o[0]), 0);
      chk("reset rdaddr", 32'(ra_o[0]), 0);
      chk("reset rd_valid", 32'(rv_o[0]), 0);
      // single read: latency 1 without output register, 2 with it
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      settle;
      chk("lat1 u1 rd_valid", 32'(rv_o[1]), 1);
      chk("lat2 u0 oreg_en", 32'(oe_o[0]), 1);
      chk("lat2 u0 rd_valid early", 32'(rv_o[0]), 0);
      @(posedge clock);
      settle;
      chk("lat2 u0 rd_valid", 32'(rv_o[0]), 1);
      chk("lat1 u1 rd_valid gone", 32'(rv_o[1]), 0);
      // sclr wins over a concurrent write
      drive(1, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 0);
      settle;
      chk("sclr u0 capacity", 32'(cap_o[0]), 0);
      chk("sclr u0 wraddr", 32'(wa_o[0]), 0);
      chk("sclr u0 rdaddr", 32'(ra_o[0]), 0);
      chk("sclr u2 capacity", 32'(cap_o[2]), 0);
      // fill 32 words, then writes against full
      repeat (32) drive(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 1, 0, 0);
         settle;
         chk("full u0 wrreq_safe", 32'(ws_o[0]), 0);
      end
      drive(0, 0, 1, 0, 0);
      settle;
      chk("full u0 wraddr", 32'(wa_o[0]), 0);
      chk("full u0 capacity", 32'(cap_o[0]), 0);
      chk("unguarded u2 wraddr", 32'(wa_o[2]), 3);
      chk("unguarded u2 capacity", 32'(cap_o[2]), 3);
      // read+write while full
      drive(1, 1, 1, 0, 0);
      settle;
      chk("rw u0 wrreq_safe", 32'(ws_o[0]), 0);
      chk("rw u0 rdreq_safe", 32'(rs_o[0]), 1);
      chk("rw u1 wrreq_safe", 32'(ws_o[1]), 1);
      chk("rw u1 rdreq_safe", 32'(rs_o[1]), 1);
      drive(0, 0, 1, 0, 0);
      settle;
      chk("rw u1 capacity", 32'(cap_o[1]), 0);
      chk("rw u1 wraddr", 32'(wa_o[1]), 9);
      chk("rw u1 rdaddr", 32'(ra_o[1]), 1);
      chk("rw u0 capacity", 32'(cap_o[0]), 31);
      chk("rw u0 rdaddr", 32'(ra_o[0]), 1);
      // reads against empty
      drive(0, 0, 0, 1, 1);
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 0, 1, 0);
         settle;
         chk("empty u0 rdreq_safe", 32'(rs_o[0]), 0);
         chk("empty u1 rdreq_safe", 32'(rs_o[1]), 0);
      end
      drive(0, 0, 0, 1, 0);
      settle;
      @(posedge clock);
      settle;
      chk("empty u0 rdaddr", 32'(ra_o[0]), 0);
      chk("empty u0 rd_valid", 32'(rv_o[0]), 0);
      chk("underflow u2 rdaddr", 32'(ra_o[2]), 4);
      chk("underflow u2 capacity", 32'(cap_o[2]), 28);
      // non-power-of-two depth wrap
      drive(0, 0, 0, 1, 1);
      for (int k = 0; k < 30; k++) begin
         drive(1, 0, 0, 0, 0);
         drive(0, 1, 0, 0, 0);
      end
      drive(0, 0, 0, 1, 0);
      settle;
      chk("wrap u1 wraddr", 32'(wa_o[1]), 6);
      chk("wrap u1 rdaddr", 32'(ra_o[1]), 6);
      chk("wrap u1 capacity", 32'(cap_o[1]), 0);
      // aclr with capacity 7 and a read in flight
      drive(0, 0, 0, 1, 1);
      repeat (8) drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      @(posedge clock);
      #1;
      chk("pre-aclr u0 capacity", 32'(cap_o[0]), 7);
      chk("pre-aclr u0 oreg_en", 32'(oe_o[0]), 1);
      #1;
      wrreq = 0;
      rdreq = 0;
      empty = 1;
      aclr = 1;
      #1;
      chk("aclr u0 capacity", 32'(cap_o[0]), 0);
      chk("aclr u0 wraddr", 32'(wa_o[0]), 0);
      chk("aclr u0 rdaddr", 32'(ra_o[0]), 0);
      chk("aclr u0 oreg_en", 32'(oe_o[0]), 0);
      chk("aclr u0 rd_valid", 32'(rv_o[0]), 0);
      @(posedge clock);
      #2;
      aclr = 0;
      settle;
      chk("post-aclr u0 rd_valid", 32'(rv_o[0]), 0);
      @(posedge clock);
      settle;
      chk("post-aclr u0 rd_valid late", 32'(rv_o[0]), 0);
      repeat (3) drive(0, 0, 0, 1, 0);
      settle;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
